bit_index_scanner: RTL and testbench

Parametrised set-bit locator with valid/ready handshakes on both sides. Accepts one WIDTH-bit word from a source and emits the position of its set bits to a sink, either only the highest-priority bit or every set bit as a sequence of beats, in MSB-first or LSB-first order. It sits between a producer of bit masks (request/flag vectors) and a consumer that needs encoded indices, one index per handshake.

---
 rtl/bit_index_scanner_if.sv | 27 ++
 rtl/bit_index_scanner.sv | 82 ++++++++
 tb/tb_bit_index_scanner.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/bit_index_scanner_if.sv
// Handshake bundle between a bit-mask source, the scanner and an index sink.
// The slave side is the scanner; the master side drives words in and takes beats out.
interface bit_index_scanner_if #(
   parameter int WIDTH = 8
);
   localparam int IDXW = $clog2(WIDTH);

   logic             vld_src;
   logic [WIDTH-1:0] data_in;
   logic             mode_all;
   logic             rdy_src;
   logic [IDXW-1:0]  index;
   logic             last;
   logic             zero;
   logic             vld_sink;
   logic             rdy_sink;

   modport master (
      output vld_src, data_in, mode_all, rdy_sink,
      input  rdy_src, index, last, zero, vld_sink
   );

   modport slave (
      input  vld_src, data_in, mode_all, rdy_sink,
      output rdy_src, index, last, zero, vld_sink
   );
endinterface

// File: rtl/bit_index_scanner.sv
// Captures one WIDTH-bit mask and emits the indices of its set bits, one per
// sink handshake, either the first set bit only or every set bit in scan order.
//
// state | meaning
// IDLE  | ready for a new word, no beat offered
// SCAN  | offering the priority-encoded index of the remaining mask
module bit_index_scanner #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   bit_index_scanner_if.slave   bus
);
   localparam int IDXW = $clog2(WIDTH);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           state;
   logic [WIDTH-1:0] rem;
   logic             mode_ff;

   logic [IDXW-1:0]  enc;
   logic             rem_zero;
   logic             rem_one;
   logic             last_c;
   logic             scan;

   // Later hits overwrite earlier ones, so the loop direction picks the priority.
   always_comb begin
      enc = '0;
      if (MSB_FIRST) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (rem[i]) enc = IDXW'(i);
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rem[i]) enc = IDXW'(i);
         end
      end
   end

   assign rem_zero = (rem == '0);
   assign rem_one  = ~rem_zero && ((rem & (rem - WIDTH'(1))) == '0);
   assign last_c   = rem_zero | ~mode_ff | rem_one;
   assign scan     = (state == SCAN);

   assign bus.rdy_src  = (state == IDLE) & ~rst;
   assign bus.vld_sink = scan;
   assign bus.index    = scan ? enc : '0;
   assign bus.last     = scan & last_c;
   assign bus.zero     = scan & rem_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         rem     <= '0;
         mode_ff <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.vld_src) begin
                  rem     <= bus.data_in;
                  mode_ff <= bus.mode_all;
                  state   <= SCAN;
               end
            end
            SCAN: begin
               if (bus.rdy_sink) begin
                  if (last_c) begin
                     rem   <= '0;
                     state <= IDLE;
                  end else begin
                     rem <= rem & ~(WIDTH'(1) << enc);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_bit_index_scanner.sv
// Randomised bench for bit_index_scanner: an 8-bit MSB-first and a 16-bit
// LSB-first instance, checked against a set-bit list model.
module tb_bit_index_scanner;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   bit_index_scanner_if #(.WIDTH(8))  b8 ();
   bit_index_scanner_if #(.WIDTH(16)) b16 ();

   bit_index_scanner #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (b8)
   );

   bit_index_scanner #(.WIDTH(16), .MSB_FIRST(1'b0)) dut16 (
      .clk (clk),
      .rst (rst),
      .bus (b16)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] o_rdy(input int w);
      return (w == 8) ? 32'(b8.rdy_src) : 32'(b16.rdy_src);
   endfunction
   function automatic logic [31:0] o_vld(input int w);
      return (w == 8) ? 32'(b8.vld_sink) : 32'(b16.vld_sink);
   endfunction
   function automatic logic [31:0] o_idx(input int w);
      return (w == 8) ? 32'(b8.index) : 32'(b16.index);
   endfunction
   function automatic logic [31:0] o_last(input int w);
      return (w == 8) ? 32'(b8.last) : 32'(b16.last);
   endfunction
   function automatic logic [31:0] o_zero(input int w);
      return (w == 8) ? 32'(b8.zero) : 32'(b16.zero);
   endfunction

   task automatic drv(input int w, input logic v, input logic [15:0] d, input logic m,
                      input logic r);
      if (w == 8) begin
         b8.vld_src = v; b8.data_in = d[7:0]; b8.mode_all = m; b8.rdy_sink = r;
      end else begin
         b16.vld_src = v; b16.data_in = d; b16.mode_all = m; b16.rdy_sink = r;
      end
   endtask

   // Entered just after a falling edge with the instance idle. The expected
   // beat list is every set bit in scan order, trimmed to one beat unless m.
   task automatic run(input string tag, input int w, input logic [15:0] d, input logic m,
                      input int max_stall, input int stall_at, input int stall_n);
      int q[$];
      bit zw;
      int stalls;
      for (int k = 0; k < w; k++) begin
         int b;
         b = (w == 8) ? (w - 1 - k) : k;
         if (d[b]) q.push_back(b);
      end
      zw = (q.size() == 0);
      if (zw) q.push_back(0);
      if (!m) while (q.size() > 1) void'(q.pop_back());

      chk({tag, ".rdy_idle"}, o_rdy(w), 1);
      chk({tag, ".vld_idle"}, o_vld(w), 0);
      chk({tag, ".idx_idle"}, o_idx(w), 0);
      drv(w, 1'b1, d, m, 1'b0);
      @(negedge clk);
      for (int j = 0; j < q.size(); j++) begin
         stalls = (j == stall_at) ? stall_n : int'($urandom_range(0, max_stall));
         for (int s = 0; s <= stalls; s++) begin
            chk({tag, ".vld"},  o_vld(w),  1);
            chk({tag, ".rdy"},  o_rdy(w),  0);
            chk({tag, ".idx"},  o_idx(w),  q[j]);
            chk({tag, ".last"}, o_last(w), (j == q.size() - 1) ? 1 : 0);
            chk({tag, ".zero"}, o_zero(w), zw ? 1 : 0);
            drv(w, 1'($urandom % 2), 16'($urandom), 1'($urandom % 2), (s == stalls));
            @(negedge clk);
         end
      end
      drv(w, 1'b0, 16'h0, 1'b0, 1'b0);
      chk({tag, ".vld_done"}, o_vld(w), 0);
      chk({tag, ".rdy_done"}, o_rdy(w), 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      drv(8, 1'b0, 16'h0, 1'b0, 1'b0);
      drv(16, 1'b0, 16'h0, 1'b0, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.rdy",  o_rdy(8),  0);
      chk("rst.vld",  o_vld(8),  0);
      chk("rst.idx",  o_idx(8),  0);
      chk("rst.last", o_last(8), 0);
      chk("rst.zero", o_zero(8), 0);
      chk("rst.rdy16", o_rdy(16), 0);
      rst = 1'b0;
      #1;
      chk("rst.rdy_after", o_rdy(8), 1);
      @(negedge clk);

      run("all_a4",   8, 16'h00A4, 1'b1, 0, -1, 0);
      run("first_a4", 8, 16'h00A4, 1'b0, 0, -1, 0);
      run("zero8",    8, 16'h0000, 1'b1, 0, -1, 0);
      run("zero8_m0", 8, 16'h0000, 1'b0, 0, -1, 0);
      run("stall_a4", 8, 16'h00A4, 1'b1, 0, 1, 3);
      run("lsb_8001", 16, 16'h8001, 1'b1, 0, -1, 0);
      run("full8",    8, 16'h00FF, 1'b1, 0, -1, 0);
      run("lsb_zero", 16, 16'h0000, 1'b1, 0, -1, 0);

      // Reset between beats 1 and 2: remaining beats must vanish.
      drv(8, 1'b1, 16'h00A4, 1'b1, 1'b0);
      @(negedge clk);
      drv(8, 1'b0, 16'h0, 1'b0, 1'b1);
      chk("mid.idx0", o_idx(8), 7);
      @(negedge clk);
      chk("mid.idx1", o_idx(8), 5);
      chk("mid.last1", o_last(8), 0);
      rst = 1'b1;
      drv(8, 1'b0, 16'h0, 1'b0, 1'b0);
      #1;
      chk("mid.vld_rst", o_vld(8), 0);
      chk("mid.rdy_rst", o_rdy(8), 0);
      chk("mid.idx_rst", o_idx(8), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("mid.rdy_after", o_rdy(8), 1);
      chk("mid.vld_after", o_vld(8), 0);
      run("after_rst", 8, 16'h0010, 1'b0, 0, -1, 0);

      for (int i = 0; i < 40; i++) begin
         d = 16'($urandom);
         if (i % 7 == 0) d = 16'h0;
         if (i % 5 == 1) d = 16'(1) << $urandom_range(0, 15);
         run("rnd8", 8, d & 16'h00FF, 1'($urandom % 2), 2, -1, 0);
      end
      for (int i = 0; i < 30; i++) begin
         d = 16'($urandom);
         if (i % 6 == 0) d = 16'h0;
         if (i % 4 == 1) d = 16'(1) << $urandom_range(0, 15);
         run("rnd16", 16, d, 1'($urandom % 2), 2, -1, 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
